// File: rtl/rvfi_lane_serializer.sv
// Compacts up to LANES committed RVFI lanes per cycle into a record FIFO and emits one record per cycle.
// Records are visible one cycle after the write edge; the input side has no backpressure and drops whole bundles that do not fit.
module rvfi_lane_serializer #(
  parameter int LANES = 4,
  parameter int DEPTH = 16,
  parameter int PW    = 311
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES-1:0]       in_commit,
  input  logic [LANES-1:0]       in_halt,
  input  logic [LANES-1:0]       in_trap,
  input  logic [64*LANES-1:0]    in_order,
  input  logic [PW*LANES-1:0]    in_payload,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [63:0]            out_order,
  output logic                   out_halt,
  output logic                   out_trap,
  output logic [PW-1:0]          out_payload,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   halted,
  output logic [15:0]            errcode
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LANES + 1);
  localparam int SW = AW + 2;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

  typedef struct packed {
    logic [63:0]   order;
    logic          halt;
    logic          trap;
    logic [PW-1:0] payload;
  } rec_t;

  rec_t          mem [DEPTH];
  state_e        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic [3:0]    err_q, err_d;
  logic [63:0]   exp_q, exp_d;

  logic [LANES-1:0] keep;
  logic [CW-1:0]    rank [LANES];
  logic [AW-1:0]    waddr [LANES];
  logic [CW-1:0]    n_push;
  logic             halt_kept, tail_drop, mismatch;
  logic [63:0]      last_next;
  logic [SW-1:0]    free;
  logic             overflow, noncontig, do_write, pop;

  assign out_valid   = (occ_q != '0);
  assign pop         = out_valid && out_ready;
  assign out_order   = mem[rptr_q].order;
  assign out_halt    = mem[rptr_q].halt;
  assign out_trap    = mem[rptr_q].trap;
  assign out_payload = mem[rptr_q].payload;
  assign occupancy   = occ_q;
  assign halted      = (state_q == HALTED);
  assign errcode     = {12'b0, err_q};

  // Lanes are kept up to and including the first committed halt lane; each kept lane's
  // rank is its slot offset from wptr and its index into the expected-order sequence.
  always_comb begin
    keep      = '0;
    halt_kept = 1'b0;
    tail_drop = 1'b0;
    mismatch  = 1'b0;
    n_push    = '0;
    last_next = exp_q;
    for (int i = 0; i < LANES; i++) begin
      rank[i]  = n_push;
      waddr[i] = wptr_q + AW'(n_push);
      if (in_commit[i]) begin
        if (halt_kept) begin
          tail_drop = 1'b1;
        end else begin
          keep[i]   = 1'b1;
          halt_kept = in_halt[i];
          if (in_order[64*i +: 64] != exp_q + 64'(n_push)) mismatch = 1'b1;
          last_next = in_order[64*i +: 64] + 64'd1;
          n_push    = n_push + CW'(1);
        end
      end
    end
  end

  always_comb begin
    free      = SW'(DEPTH) - SW'(occ_q) + SW'(pop);
    overflow  = SW'(n_push) > free;
    noncontig = (in_commit & (in_commit + LANES'(1))) != '0;
    do_write  = (state_q == RUN) && !overflow && (n_push != '0);
    state_d   = state_q;
    err_d     = err_q;
    exp_d     = exp_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q + AW'(pop);
    occ_d     = occ_q + (do_write ? (AW+1)'(n_push) : '0) - (AW+1)'(pop);
    case (state_q)
      RUN: begin
        if (overflow)  err_d[0] = 1'b1;
        if (noncontig) err_d[2] = 1'b1;
        if (tail_drop) err_d[3] = 1'b1;
        if (do_write) begin
          wptr_d = wptr_q + AW'(n_push);
          exp_d  = last_next;
          if (mismatch)  err_d[1] = 1'b1;
          if (halt_kept) state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (in_commit != '0) err_d[3] = 1'b1;
        if (pop && out_halt) state_d = HALTED;
      end
      HALTED: begin
        if (in_commit != '0) err_d[3] = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      wptr_q  <= '0;
      rptr_q  <= '0;
      occ_q   <= '0;
      err_q   <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      occ_q   <= occ_d;
      err_q   <= err_d;
      exp_q   <= exp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < LANES; i++) begin
        if (keep[i]) mem[waddr[i]] <= {in_order[64*i +: 64], in_halt[i], in_trap[i], in_payload[PW*i +: PW]};
      end
    end
  end

endmodule
